// File: rtl/am_env_detect.sv
// am_env_detect: AM envelope detector sitting behind the DC-offset estimator.
// Subtracts the DC estimate from each raw ADC sample, rectifies the result and
// reduces a window of 2^DECIM_LOG2 accepted samples to a single envelope value
// (mean or peak). The first SETTLE_SAMPLES samples after reset are thrown away
// while the upstream DC loop converges.
module am_env_detect #(
   parameter int DECIM_LOG2     = 2,
   parameter int PEAK_MODE      = 0,
   parameter int SETTLE_SAMPLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   input  logic [7:0] dc,
   output logic [7:0] env,
   output logic       env_valid,
   output logic       env_clip,
   output logic       settled
);

   localparam int AW = 8 + DECIM_LOG2;
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_SAMPLES - 1);

   typedef enum logic {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } state_t;

   state_t state, state_nx;

   logic [7:0] din_r, dc_r;
   logic       v1, clip1;

   logic [8:0] diff, neg_diff;
   logic [7:0] mag;
   logic [7:0] mag_r;
   logic       v2, clip2;

   logic [15:0]           scnt;
   logic                  settle_done;
   logic [AW-1:0]         acc, acc_nx, sum;
   logic [7:0]            peak, win_result;
   logic [DECIM_LOG2-1:0] wcnt;
   logic                  clip_acc;
   logic                  run_take, win_last;

   // Stage 1: capture the sample together with the DC estimate that belongs
   // to it, so later changes of dc never affect a sample already in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1    <= 1'b0;
         din_r <= 8'd0;
         dc_r  <= 8'd0;
         clip1 <= 1'b0;
      end else begin
         v1 <= din_valid;
         if (din_valid) begin
            din_r <= din;
            dc_r  <= dc;
            clip1 <= (din == 8'd0) || (din == 8'd255);
         end
      end
   end

   // Remove DC and rectify; the 9-bit difference covers -255..+255, so the
   // magnitude always fits in 8 bits (-255 becomes 255).
   always_comb begin
      diff     = {1'b0, din_r} - {1'b0, dc_r};
      neg_diff = 9'd0 - diff;
      mag      = diff[8] ? neg_diff[7:0] : diff[7:0];
   end

   // Stage 2: register the magnitude; bubbles travel with v2.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2    <= 1'b0;
         mag_r <= 8'd0;
         clip2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            mag_r <= mag;
            clip2 <= clip1;
         end
      end
   end

   // Settle-phase state register; with no settle samples we start in RUN.
   always_ff @(posedge clk) begin
      if (rst) state <= (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
      else     state <= state_nx;
   end

   // Leave SETTLE on the stage-2 sample that completes the discard count;
   // that sample itself is still discarded. RUN is only left through reset.
   always_comb begin
      state_nx    = state;
      settle_done = 1'b0;
      if (state == SETTLE && v2 && scnt == SETTLE_LAST) begin
         settle_done = 1'b1;
         state_nx    = RUN;
      end
   end

   // Count discarded samples while settling.
   always_ff @(posedge clk) begin
      if (rst)                                     scnt <= 16'd0;
      else if (state == SETTLE && v2 && !settle_done) scnt <= scnt + 16'd1;
   end

   assign settled = (state == RUN);

   // Window arithmetic: running sum or running max, plus the value that the
   // window reports if the current sample is its last one.
   always_comb begin
      run_take   = v2 && (state == RUN);
      win_last   = (wcnt == {DECIM_LOG2{1'b1}});
      sum        = acc + AW'(mag_r);
      peak       = (acc[7:0] > mag_r) ? acc[7:0] : mag_r;
      acc_nx     = sum;
      win_result = sum[AW-1:DECIM_LOG2];
      if (PEAK_MODE != 0) begin
         acc_nx     = AW'(peak);
         win_result = peak;
      end
   end

   // Stage 3: accumulate accepted samples and publish one result per window,
   // restarting the window in the same edge so no sample is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         clip_acc  <= 1'b0;
         wcnt      <= '0;
         env       <= 8'd0;
         env_clip  <= 1'b0;
         env_valid <= 1'b0;
      end else begin
         env_valid <= 1'b0;
         if (run_take) begin
            if (win_last) begin
               env       <= win_result;
               env_clip  <= clip_acc | clip2;
               env_valid <= 1'b1;
               acc       <= '0;
               clip_acc  <= 1'b0;
               wcnt      <= '0;
            end else begin
               acc      <= acc_nx;
               clip_acc <= clip_acc | clip2;
               wcnt     <= wcnt + 1'b1;
            end
         end
      end
   end

endmodule
